instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the `Memory` block. It owns the program counter, issues word reads (`mem_addr`/`mem_rstrb`), captures `mem_rdata` one cycle later and presents the instruction to decode via a valid/ready handshake. It accepts redirects (jumps, branches, calls, returns) from execute at any time and discards any fetch already in flight.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port, decode handshake and redirect input.
// The master modport is the fetch unit; the slave modport is its environment
// (memory, decode and execute seen as one peer).
interface instr_fetch_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    modport master (
        output mem_addr, mem_rstrb, instr, instr_pc, instr_valid, misaligned,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_rstrb, instr, instr_pc, instr_valid, misaligned,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read per instruction,
// captures the returned word and offers it to decode over valid/ready.
// Redirects from execute restart fetch and discard any read in flight.
// Optional feature macro: FETCH_MISALIGN_EN -- a redirect to a non word-aligned
// target halts fetch and raises the sticky misaligned flag until reset.
// Without it the low two target bits are dropped and misaligned stays 0.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        load_instr;
    logic        redirect_take;
    logic [31:0] target_aligned;

    // Word-aligned redirect target; the low bits are only inspected by the
    // misalignment check.
    assign target_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_EN
    logic misaligned_q;
    logic target_bad;
    logic set_misaligned;

    assign target_bad    = (bus.redirect_pc[1:0] != 2'b00);
    // A halted unit ignores redirects; only reset brings it back.
    assign redirect_take = bus.redirect && (state_q != S_HALT);
`else
    assign redirect_take = bus.redirect;
`endif

    // Next-state and next-PC selection; a redirect overrides every normal transition.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_instr = 1'b0;
`ifdef FETCH_MISALIGN_EN
        set_misaligned = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d    = S_VALID;
                load_instr = 1'b1;
            end
            S_VALID: begin
                // instr_valid is high throughout VALID, so ready alone completes the handshake.
                if (bus.instr_ready) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + 32'd4;
                end
            end
`ifdef FETCH_MISALIGN_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_take) begin
            // Suppressing the capture discards the read landing in WAIT.
            load_instr = 1'b0;
            state_d    = S_FETCH;
            pc_d       = target_aligned;
`ifdef FETCH_MISALIGN_EN
            if (target_bad) begin
                state_d        = S_HALT;
                pc_d           = bus.redirect_pc;
                set_misaligned = 1'b1;
            end
`endif
        end
    end

    // State, PC and instruction registers; valid is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == S_VALID);
            if (load_instr) begin
                instr_q    <= bus.mem_rdata;
                instr_pc_q <= pc_q;
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (set_misaligned) begin
            misaligned_q <= 1'b1;
        end
    end

    assign bus.misaligned = misaligned_q;
`else
    assign bus.misaligned = 1'b0;
`endif

    assign bus.mem_addr    = pc_q;
    assign bus.mem_rstrb   = (state_q == S_FETCH);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run, all
// checked against a behavioural model that tracks the PC and the number of
// clock edges until the next instruction is presented.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory: registered read, data available the cycle after the strobe.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end

    int total = 0;
    int bad   = 0;

    // Model: m_wait = clock edges until an instruction is on offer (0 = offered).
    logic [31:0] m_pc;
    int          m_wait;
    bit          m_halt;
    bit          m_mis;

    function automatic bit exp_valid();
        return !m_halt && (m_wait == 0);
    endfunction

    function automatic bit exp_strobe();
        return !m_halt && (m_wait == 2);
    endfunction

    // Apply the current inputs across one rising edge and advance the model.
    task automatic tick();
        logic        r, rd, rdy;
        logic [31:0] tgt;
        r   = reset;
        rd  = bus.redirect;
        rdy = bus.instr_ready;
        tgt = bus.redirect_pc;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = RESET_PC; m_wait = 3; m_halt = 1'b0; m_mis = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (rd) begin
            if (MIS_EN && tgt[1:0] != 2'b00) begin
                m_halt = 1'b1; m_mis = 1'b1; m_pc = tgt;
            end else begin
                m_pc = {tgt[31:2], 2'b00}; m_wait = 2;
            end
        end else if (m_wait == 0) begin
            if (rdy) begin
                m_pc = m_pc + 32'd4; m_wait = 2;
            end
        end else begin
            m_wait = m_wait - 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
        total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
        total++; if (bus.mem_rstrb !== 1'b0) begin bad++; $display("FAIL reset_rstrb: got %0b want 0", bus.mem_rstrb); end
        total++; if (bus.mem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", bus.mem_addr, RESET_PC); end
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned: got %0b want 0", bus.misaligned); end
        reset = 1'b0;
        tick(); // cycle 1
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL first_strobe: got rstrb=%0b addr=%h want 1 0", bus.mem_rstrb, bus.mem_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL first_early_valid_c1: got %0b want 0", bus.instr_valid); end
        tick(); // cycle 2
        total++; if (bus.instr_valid !== 1'b0 || bus.mem_rstrb !== 1'b0) begin bad++; $display("FAIL first_wait: got valid=%0b rstrb=%0b want 0 0", bus.instr_valid, bus.mem_rstrb); end
        tick(); // cycle 3
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %0b want 1", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0000_0513 || bus.instr_pc !== 32'h0) begin bad++; $display("FAIL first_instr: got %h@%h want 00000513@0", bus.instr, bus.instr_pc); end
        tick(); // cycle 4
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h4) begin bad++; $display("FAIL second_strobe: got rstrb=%0b addr=%h want 1 4", bus.mem_rstrb, bus.mem_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL drop_after_handshake: got %0b want 0", bus.instr_valid); end
    endtask

    // Enters in FETCH of 0x4 (end of test_reset).
    task automatic test_stall();
        bus.instr_ready = 1'b0;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.instr !== mem[1]) begin bad++; $display("FAIL stall_enter: got v=%0b %h@%h want 1 %h@4", bus.instr_valid, bus.instr, bus.instr_pc, mem[1]); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.instr !== mem[1] || bus.mem_rstrb !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d]: got v=%0b rstrb=%0b %h@%h want 1 0 %h@4", i, bus.instr_valid, bus.mem_rstrb, bus.instr, bus.instr_pc, mem[1]); end
        end
        bus.instr_ready = 1'b1;
        tick();
        total++; if (bus.instr_valid !== 1'b0 || bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h8) begin bad++; $display("FAIL stall_release: got v=%0b rstrb=%0b addr=%h want 0 1 8", bus.instr_valid, bus.mem_rstrb, bus.mem_addr); end
    endtask

    // Enters in FETCH of 0x8.
    task automatic test_redirect_wait();
        tick(); // WAIT of fetch at 0x8
        bus.redirect = 1'b1; bus.redirect_pc = 32'h18;
        tick(); // m+1
        bus.redirect = 1'b0;
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h18 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rdw_fetch: got rstrb=%0b addr=%h v=%0b want 1 18 0", bus.mem_rstrb, bus.mem_addr, bus.instr_valid); end
        tick(); // m+2
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rdw_discard: got v=%0b pc=%h want 0", bus.instr_valid, bus.instr_pc); end
        tick(); // m+3
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h18 || bus.instr !== mem[6]) begin bad++; $display("FAIL rdw_valid: got v=%0b %h@%h want 1 %h@18", bus.instr_valid, bus.instr, bus.instr_pc, mem[6]); end
    endtask

    // Enters in VALID with ready high; redirect to 0xC first to set up.
    task automatic test_redirect_handshake();
        bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'hC;
        tick();
        bus.redirect = 1'b0;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hC) begin bad++; $display("FAIL rdh_setup: got v=%0b pc=%h want 1 c", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h4;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 32'h4 || bus.mem_rstrb !== 1'b1) begin bad++; $display("FAIL rdh_fetch: got v=%0b rstrb=%0b addr=%h want 0 1 4", bus.instr_valid, bus.mem_rstrb, bus.mem_addr); end
        bus.instr_ready = 1'b0;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin bad++; $display("FAIL rdh_target: got v=%0b pc=%h want 1 4", bus.instr_valid, bus.instr_pc); end
    endtask

    // Enters in VALID at 0x4; redirect in FETCH and on consecutive cycles.
    task automatic test_redirect_consecutive();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
        tick();
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h20) begin bad++; $display("FAIL rdc_first: got rstrb=%0b addr=%h want 1 20", bus.mem_rstrb, bus.mem_addr); end
        bus.redirect_pc = 32'h28;
        tick();
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h28) begin bad++; $display("FAIL rdc_second: got rstrb=%0b addr=%h want 1 28", bus.mem_rstrb, bus.mem_addr); end
        bus.redirect_pc = 32'h30;
        tick();
        bus.redirect = 1'b0;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h30 || bus.instr !== mem[12]) begin bad++; $display("FAIL rdc_last_wins: got v=%0b %h@%h want 1 %h@30", bus.instr_valid, bus.instr, bus.instr_pc, mem[12]); end
    endtask

    // Enters in VALID at 0x30 with ready low.
    task automatic test_reset_in_valid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.instr_valid !== 1'b0 || bus.mem_addr !== RESET_PC || bus.instr !== 32'h0 || bus.mem_rstrb !== 1'b0) begin bad++; $display("FAIL riv_reset: got v=%0b addr=%h instr=%h rstrb=%0b want 0 %h 0 0", bus.instr_valid, bus.mem_addr, bus.instr, bus.mem_rstrb, RESET_PC); end
        tick();
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== RESET_PC) begin bad++; $display("FAIL riv_restart: got rstrb=%0b addr=%h want 1 %h", bus.mem_rstrb, bus.mem_addr, RESET_PC); end
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RESET_PC || bus.instr !== mem[0]) begin bad++; $display("FAIL riv_valid: got v=%0b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, mem[0], RESET_PC); end
    endtask

    // PC increment wraps modulo 2^32.
    task automatic test_wrap();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.instr_ready = 1'b1;
        tick();
        bus.redirect = 1'b0;
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== mem[63]) begin bad++; $display("FAIL wrap_top: got v=%0b %h@%h want 1 %h@fffffffc", bus.instr_valid, bus.instr, bus.instr_pc, mem[63]); end
        tick();
        total++; if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero: got rstrb=%0b addr=%h want 1 0", bus.mem_rstrb, bus.mem_addr); end
    endtask

    task automatic test_misalign();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h1A;
        tick();
`ifdef FETCH_MISALIGN_EN
        total++; if (bus.misaligned !== 1'b1 || bus.mem_rstrb !== 1'b0 || bus.mem_addr !== 32'h1A) begin bad++; $display("FAIL mis_halt: got mis=%0b rstrb=%0b addr=%h want 1 0 1a", bus.misaligned, bus.mem_rstrb, bus.mem_addr); end
        bus.redirect_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.redirect = 1'b0;
            total++; if (bus.misaligned !== 1'b1 || bus.mem_rstrb !== 1'b0 || bus.instr_valid !== 1'b0 || bus.mem_addr !== 32'h1A) begin bad++; $display("FAIL mis_stuck[%0d]: got mis=%0b rstrb=%0b v=%0b addr=%h want 1 0 0 1a", i, bus.misaligned, bus.mem_rstrb, bus.instr_valid, bus.mem_addr); end
        end
`else
        bus.redirect = 1'b0;
        total++; if (bus.misaligned !== 1'b0 || bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'h18) begin bad++; $display("FAIL mis_forced: got mis=%0b rstrb=%0b addr=%h want 0 1 18", bus.misaligned, bus.mem_rstrb, bus.mem_addr); end
        tick(); tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h18 || bus.instr !== mem[6]) begin bad++; $display("FAIL mis_fetch: got v=%0b %h@%h want 1 %h@18", bus.instr_valid, bus.instr, bus.instr_pc, mem[6]); end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.misaligned !== 1'b0) begin bad++; $display("FAIL mis_cleared: got %0b want 0", bus.misaligned); end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int c = 0; c < 800; c++) begin
            reset           = ($urandom_range(0, 99) < 2);
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.redirect    = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FC);
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            bus.redirect_pc = t;
            tick();
            total++; if (bus.instr_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, bus.instr_valid, exp_valid()); end
            total++; if (bus.mem_rstrb !== exp_strobe()) begin bad++; $display("FAIL rnd_rstrb c%0d: got %0b want %0b", c, bus.mem_rstrb, exp_strobe()); end
            total++; if (bus.mem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.mem_addr, m_pc); end
            total++; if (bus.misaligned !== m_mis) begin bad++; $display("FAIL rnd_misaligned c%0d: got %0b want %0b", c, bus.misaligned, m_mis); end
            if (exp_valid()) begin
                total++; if (bus.instr_pc !== m_pc || bus.instr !== mem[m_pc[7:2]]) begin bad++; $display("FAIL rnd_instr c%0d: got %h@%h want %h@%h", c, bus.instr, bus.instr_pc, mem[m_pc[7:2]], m_pc); end
            end
        end
        reset = 1'b0; bus.redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0513;
        m_pc = RESET_PC; m_wait = 3; m_halt = 1'b0; m_mis = 1'b0;
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_redirect_consecutive();
        test_reset_in_valid();
        test_wrap();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
